code_serializer: RTL

CODE_SERIALIZER -- requirements
Module: code_serializer

---
 rtl/code_serializer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/code_serializer.sv
// Parallel-to-serial code emitter with a one-entry holding register.
// Each code goes out MSB first, one bit per clock, and is followed by GAP idle cycles.
// data_out, busy and frame_start are registered; code_ready is the only combinational output.
module code_serializer #(
    parameter int unsigned CODE_W = 4,
    parameter int unsigned GAP    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CODE_W-1:0] code_in,
    input  logic              code_valid,
    output logic              code_ready,
    output logic              data_out,
    output logic              busy,
    output logic              frame_start
);

    localparam int unsigned CNT_W    = $clog2(CODE_W);
    localparam int unsigned GAP_W    = 4;
    localparam int unsigned GAP_LAST = (GAP > 0) ? GAP - 1 : 0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_e;

    state_e              state_q,    state_d;
    logic [CODE_W-1:0]   hold_q,     hold_d;
    logic                hold_vld_q, hold_vld_d;
    logic [CODE_W-1:0]   shift_q,    shift_d;
    logic [CNT_W-1:0]    bit_cnt_q,  bit_cnt_d;
    logic [GAP_W-1:0]    gap_cnt_q,  gap_cnt_d;
    logic                data_q,     data_d;
    logic                busy_q,     busy_d;
    logic                fstart_q,   fstart_d;
    logic                reload;

    // Holding register is the only buffer; ready simply reflects its emptiness.
    assign code_ready  = ~hold_vld_q;
    assign data_out    = data_q;
    assign busy        = busy_q;
    assign frame_start = fstart_q;

    // State and datapath registers; reset discards any partial or held code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            data_q     <= 1'b0;
            busy_q     <= 1'b0;
            fstart_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            data_q     <= data_d;
            busy_q     <= busy_d;
            fstart_q   <= fstart_d;
        end
    end

    // Next-state and next-output logic. The MSB is loaded straight into data_d on
    // reload so it appears the cycle after the reload edge; the shifter keeps the rest.
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        data_d     = 1'b0;
        fstart_d   = 1'b0;
        reload     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (hold_vld_q) begin
                    reload = 1'b1;
                end
            end
            S_SHIFT: begin
                if (bit_cnt_q == '0) begin
                    if (GAP != 0) begin
                        state_d   = S_GAP;
                        gap_cnt_d = GAP_W'(GAP_LAST);
                    end else if (hold_vld_q) begin
                        reload = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    data_d    = shift_q[CODE_W-1];
                    shift_d   = {shift_q[CODE_W-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q - CNT_W'(1);
                end
            end
            S_GAP: begin
                if (gap_cnt_q == '0) begin
                    if (hold_vld_q) begin
                        reload = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A reload empties the hold register, so it can never coincide with an accept.
        if (reload) begin
            state_d    = S_SHIFT;
            data_d     = hold_q[CODE_W-1];
            shift_d    = {hold_q[CODE_W-2:0], 1'b0};
            bit_cnt_d  = CNT_W'(CODE_W - 1);
            fstart_d   = 1'b1;
            hold_vld_d = 1'b0;
        end else if (code_valid && code_ready) begin
            hold_d     = code_in;
            hold_vld_d = 1'b1;
        end

        busy_d = (state_d != S_IDLE);
    end

endmodule
